// File: rtl/tick_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tick_sched_ctrl
// Programmable tick scheduler. Derives a one-cycle enable pulse (tick) and a
// 50%-duty square wave (clk_div_out) from clk_in with a runtime divide ratio.
// A new divisor is requested through a valid/ready handshake and is applied
// only at a period boundary (or immediately while the counter is stopped), so
// downstream logic never sees a truncated period.
//
// Parameters:
//   CNT_W        width of the period counter and of all divisor values
//   DEFAULT_DIV  divisor loaded at reset (>= 1, < 2^CNT_W)
//
// Ports:
//   clk_in       system clock, rising edge
//   rst          synchronous active-high reset
//   run          1 = counter advances, 0 = counter holds (no ticks)
//   cfg_valid    requester presents a new divisor
//   cfg_div      requested divisor, sampled when cfg_valid && cfg_ready
//   cfg_ready    no change pending, a request can be accepted
//   cfg_done     one-cycle pulse: pending divisor has just been applied
//   cfg_err      one-cycle pulse: accepted request had cfg_div == 0
//   tick         one-cycle enable pulse per div_active running cycles
//   clk_div_out  toggles on every tick
//   div_active   divisor currently in effect
//
// Build option:
//   TICK_SCHED_SQUARE_EN  defined   -> clk_div_out toggle register is built
//                         undefined -> clk_div_out tied to 0
// -----------------------------------------------------------------------------
module tick_sched_ctrl #(
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = 100
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             tick,
  output logic             clk_div_out,
  output logic [CNT_W-1:0] div_active
);

  localparam logic [CNT_W-1:0] ZERO_C        = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C         = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEFAULT_DIV_C = CNT_W'(DEFAULT_DIV);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [CNT_W-1:0] div_r;
  logic [CNT_W-1:0] div_next_s;
  logic [CNT_W-1:0] pend_r;
  logic [CNT_W-1:0] pend_next_s;
  logic             tick_r;
  logic             tick_next_s;
  logic             ready_r;
  logic             ready_next_s;
  logic             done_r;
  logic             done_next_s;
  logic             err_r;
  logic             err_next_s;
  logic             boundary_s;
  logic             accept_s;
  logic             apply_s;

  // Next-state logic for counter, handshake FSM and all registered outputs.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    div_next_s   = div_r;
    pend_next_s  = pend_r;
    tick_next_s  = 1'b0;
    done_next_s  = 1'b0;
    err_next_s   = 1'b0;
    apply_s      = 1'b0;

    // Last cycle of the current period; div_r is never 0, so no underflow.
    boundary_s = (cnt_r == (div_r - ONE_C));
    // The handshake is gated by the registered ready, which stays low for one
    // cycle after an apply even though the FSM is already back in IDLE.
    accept_s   = cfg_valid && ready_r && (state_r == ST_IDLE);

    if (run) begin
      if (boundary_s) begin
        cnt_next_s  = ZERO_C;
        tick_next_s = 1'b1;
      end else begin
        cnt_next_s  = cnt_r + ONE_C;
        tick_next_s = 1'b0;
      end
    end else begin
      cnt_next_s  = cnt_r;
      tick_next_s = 1'b0;
    end

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (cfg_div != ZERO_C) begin
            pend_next_s  = cfg_div;
            state_next_s = ST_PEND;
          end else begin
            err_next_s = 1'b1;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PEND: begin
        // The boundary tick/toggle still fires on the apply edge.
        if (!run || boundary_s) begin
          apply_s = 1'b1;
        end else begin
          apply_s = 1'b0;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    if (apply_s) begin
      div_next_s   = pend_r;
      cnt_next_s   = ZERO_C;
      done_next_s  = 1'b1;
      state_next_s = ST_IDLE;
    end else begin
      done_next_s = 1'b0;
    end

    ready_next_s = (state_next_s == ST_IDLE) && !apply_s;
  end

  // State, counter and output registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= ZERO_C;
      div_r   <= DEFAULT_DIV_C;
      pend_r  <= ZERO_C;
      tick_r  <= 1'b0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      div_r   <= div_next_s;
      pend_r  <= pend_next_s;
      tick_r  <= tick_next_s;
      ready_r <= ready_next_s;
      done_r  <= done_next_s;
      err_r   <= err_next_s;
    end
  end

`ifdef TICK_SCHED_SQUARE_EN
  logic sq_r;

  // Square-wave register: flips on the same edge that raises tick.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sq_r <= 1'b0;
    end else if (tick_next_s) begin
      sq_r <= ~sq_r;
    end else begin
      sq_r <= sq_r;
    end
  end

  assign clk_div_out = sq_r;
`else
  assign clk_div_out = 1'b0;
`endif

  assign cfg_ready  = ready_r;
  assign cfg_done   = done_r;
  assign cfg_err    = err_r;
  assign tick       = tick_r;
  assign div_active = div_r;

endmodule

// File: doc/tick_sched_ctrl.md
# tick_sched_ctrl

Programmable tick scheduler that replaces fixed-ratio clock dividers in the stopwatch/display datapath. It derives a one-cycle enable pulse (`tick`) and a 50%-duty square wave (`clk_div_out`) from `clk_in`, with a runtime-configurable divide ratio. Requesters reconfigure the ratio through a valid/ready handshake. The block applies each change only at a period boundary, so downstream logic never sees a truncated or glitched period. It sits between the top-level control FSM and every block clocked by enables (counters, display mux, blink logic).

## Interface
Parameters:
- `CNT_W`, default 27 — width of the period counter and of all divisor values.
- `DEFAULT_DIV`, default 100 — divisor loaded at reset; must be ≥1 and < 2^CNT_W.

Ports:
- `clk_in` in 1 — system clock; all logic on its rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `run` in 1 — 1 = counter advances; 0 = counter holds, no ticks.
- `cfg_valid` in 1 — requester presents a new divisor.
- `cfg_div` in CNT_W — requested divisor; sampled when `cfg_valid && cfg_ready`.
- `cfg_ready` out 1 — block can accept a request (no change pending).
- `cfg_done` out 1 — one-cycle pulse: the pending divisor has just been applied.
- `cfg_err` out 1 — one-cycle pulse: an accepted request had `cfg_div == 0` and was discarded.
- `tick` out 1 — one-cycle enable pulse, once per `div_active` running cycles.
- `clk_div_out` out 1 — toggles on every tick; period = 2·`div_active` while running.
- `div_active` out CNT_W — divisor currently in effect.

## Operation
- **Reset values:** `cnt`=0, `div_active`=`DEFAULT_DIV`, `tick`=0, `clk_div_out`=0, `cfg_ready`=1, `cfg_done`=0, `cfg_err`=0, state=IDLE, pending register cleared.
- **Counter**, each cycle with `run`=1:
  - if `cnt == div_active-1`: `cnt`←0, `tick`←1, `clk_div_out`←~`clk_div_out`;
  - else `cnt`←`cnt`+1, `tick`←0.
- **Counter**, with `run`=0: `cnt` holds, `tick`←0, `clk_div_out` holds.
- **FSM: IDLE** (`cfg_ready`=1).
  - Handshake fires when `cfg_valid`=1.
  - `cfg_div`≠0: store it in the pending register → PEND.
  - `cfg_div`=0: `cfg_err` pulses next cycle; stay IDLE.
- **FSM: PEND** (`cfg_ready`=0). Apply the pending divisor when either:
  - `run`=1 and `cnt == div_active-1` — the old period completes, and the tick/toggle for that boundary still fires; or
  - `run`=0 — apply immediately.
- **Apply action:** `div_active`←pending, `cnt`←0, `cfg_done`←1, → IDLE. `cfg_ready` returns to 1 in the cycle after the apply edge.
- **Divisor 1:** `tick` is high on every running cycle and `clk_div_out` toggles every cycle.
- **Overlapping requests:** `cfg_valid` while `cfg_ready`=0 is ignored. The requester must hold the request until it is accepted; the new request is not queued.
- **Reset mid-operation:** a pending change is discarded without a `cfg_done` pulse, and every output returns to its reset value.
- **Arithmetic:** comparisons are unsigned at CNT_W bits. `cnt` never exceeds `div_active-1`, because a change only lands with `cnt`=0.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- With `run` high from the first cycle after reset, the first `tick` is high in cycle `DEFAULT_DIV` (edge count from reset release). Later ticks follow every `div_active` cycles.
- **Handshake latency:** accept edge → `cfg_done` at the apply edge + 0; `cfg_ready` high one cycle later.
  - Worst case with `run`=1: `div_active` cycles.
  - With `run`=0: 1 cycle.
- **First period under a new divisor:** the first tick after apply occurs exactly new-`div` running cycles after the apply edge.
- A `run` transition takes effect on the same edge it is sampled.

## Configuration
- `TICK_SCHED_SQUARE_EN` defined: the `clk_div_out` toggle register is built as described above.
- `TICK_SCHED_SQUARE_EN` undefined: the register is removed and `clk_div_out` is tied to 0. `tick` and all other behaviour are unchanged.

## Test plan
- Reset, `run`=1, `DEFAULT_DIV`=100 → `tick` pulses at cycles 100, 200, 300; `clk_div_out` has period 200; `div_active`=100.
- At cycle 130, request `cfg_div`=10 with `run`=1 → `cfg_ready` low; tick at 200 with `cfg_done`=1; next ticks at 210, 220; `div_active`=10.
- `run`=0, request `cfg_div`=1 → `cfg_done` on the next edge; after `run`=1, `tick` is high every cycle and `clk_div_out` toggles every cycle.
- Request `cfg_div`=0 → `cfg_err` single pulse; `div_active` and `cfg_ready` unchanged; no `cfg_done`.
- Second `cfg_valid` (`cfg_div`=7) held while PEND (`cfg_div`=50) → only 50 is applied first; 7 is accepted the cycle after `cfg_ready` rises and applied at the next boundary.
- `rst` asserted during PEND → no `cfg_done`; `div_active`=100, `cnt`=0, all outputs at their reset values.
